// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Brief   : Round-robin inst/data arbiter onto a single SRAM-like bus with
//           address/data handshakes. Define ARB_TIMEOUT_EN to enable the
//           data-phase timeout (err pulse, rdata = 32'hDEADBEEF).
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_I_ADDR = 3'd1;
    localparam logic [2:0] S_I_DATA = 3'd2;
    localparam logic [2:0] S_D_ADDR = 3'd3;
    localparam logic [2:0] S_D_DATA = 3'd4;

    logic [2:0]  r_state;
    logic        r_lastGrantData;
    logic        w_instReq;
    logic        w_dataReq;
    logic        w_grantData;
    logic        w_timeout;
    logic [31:0] w_doneRdata;

    // A side whose data_ok is high this cycle is still finishing; its req is stale.
    assign w_instReq   = inst_req & ~inst_data_ok;
    assign w_dataReq   = data_req & ~data_data_ok;
    assign w_grantData = w_dataReq & (~w_instReq | ~r_lastGrantData);
    assign busy        = (r_state != S_IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0]  C_TIMEOUT_LAST  = 8'd254;
    localparam logic [31:0] C_TIMEOUT_RDATA = 32'hDEADBEEF;

    logic [7:0] r_timeoutCnt;
    logic       w_inData;

    assign w_inData    = (r_state == S_I_DATA) || (r_state == S_D_DATA);
    // Counter reads 254 in the last waiting cycle; it reaches 255 as the FSM returns to IDLE.
    assign w_timeout   = w_inData && !bus_data_ok && (r_timeoutCnt == C_TIMEOUT_LAST);
    assign w_doneRdata = w_timeout ? C_TIMEOUT_RDATA : bus_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeoutCnt <= 8'd0;
        end else if (((r_state == S_I_ADDR) || (r_state == S_D_ADDR)) && bus_addr_ok) begin
            r_timeoutCnt <= 8'd0;
        end else if (w_inData) begin
            r_timeoutCnt <= r_timeoutCnt + 8'd1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_doneRdata = bus_rdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_lastGrantData <= 1'b0;
            bus_req         <= 1'b0;
            bus_wr          <= 1'b0;
            bus_sel         <= 4'd0;
            bus_addr        <= 32'd0;
            bus_wdata       <= 32'd0;
            inst_rdata      <= 32'd0;
            data_rdata      <= 32'd0;
            inst_data_ok    <= 1'b0;
            data_data_ok    <= 1'b0;
            err             <= 1'b0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            err          <= w_timeout;
            case (r_state)
                S_IDLE: begin
                    if (w_instReq || w_dataReq) begin
                        bus_req         <= 1'b1;
                        r_lastGrantData <= w_grantData;
                        if (w_grantData) begin
                            r_state   <= S_D_ADDR;
                            bus_wr    <= data_wr;
                            bus_sel   <= data_sel;
                            bus_addr  <= data_addr;
                            bus_wdata <= data_wdata;
                        end else begin
                            r_state   <= S_I_ADDR;
                            bus_wr    <= 1'b0;
                            bus_sel   <= 4'b1111;
                            bus_addr  <= inst_addr;
                            bus_wdata <= 32'd0;
                        end
                    end
                end
                S_I_ADDR, S_D_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        r_state <= (r_state == S_I_ADDR) ? S_I_DATA : S_D_DATA;
                    end
                end
                S_I_DATA: begin
                    if (bus_data_ok || w_timeout) begin
                        inst_rdata   <= w_doneRdata;
                        inst_data_ok <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_D_DATA: begin
                    if (bus_data_ok || w_timeout) begin
                        data_rdata   <= w_doneRdata;
                        data_data_ok <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Brief   : Scoreboard bench for sram_arbiter with a simple bus responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_sel;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_data_ok, data_data_ok;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        busy, err;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isData;
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          reqCycles;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus responder: addr_ok after addrDelay extra cycles, data_ok one cycle later unless held.
    int          addrDelay = 0;
    bit          holdData  = 1'b0;
    int          respPhase = 0;
    int          reqCount  = 0;
    logic [31:0] capAddr, capWdata;
    logic        capWr;
    logic [3:0]  capSel;
    int          capReqCycles;
    bit          capChanged;

    initial begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (respPhase == 1) begin
                if (!holdData) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = (capAddr == 32'hBFC00000) ? 32'h24080001 : ~capAddr;
                    respPhase   = 0;
                end
            end else if (bus_req) begin
                if (reqCount == 0) begin
                    capAddr    = bus_addr;
                    capWr      = bus_wr;
                    capSel     = bus_sel;
                    capWdata   = bus_wdata;
                    capChanged = 1'b0;
                end else if (bus_addr !== capAddr || bus_wr !== capWr ||
                             bus_sel !== capSel || bus_wdata !== capWdata) begin
                    capChanged = 1'b1;
                end
                reqCount++;
                if (reqCount > addrDelay) begin
                    bus_addr_ok  = 1'b1;
                    capReqCycles = reqCount;
                    reqCount     = 0;
                    respPhase    = 1;
                end
            end
        end
    end

    // Monitor: every data_ok pops one expected completion.
    logic [31:0] prevInst = 32'd0;
    logic [31:0] prevData = 32'd0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (inst_data_ok || data_data_ok)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_data_ok: got inst=%0b data=%0b expected none", inst_data_ok, data_data_ok);
                end else begin
                    e = expQ.pop_front();
                    chk("side", {inst_data_ok, data_data_ok}, e.isData ? 2'b01 : 2'b10);
                    chk("rdata", e.isData ? data_rdata : inst_rdata, e.rdata);
                    chk("other_rdata_hold", e.isData ? inst_rdata : data_rdata, e.isData ? prevInst : prevData);
                    chk("bus_addr", capAddr, e.addr);
                    chk("bus_wr", capWr, e.wr);
                    chk("bus_sel", capSel, e.sel);
                    chk("bus_wdata", capWdata, e.wdata);
                    chk("bus_req_cycles", capReqCycles, e.reqCycles);
                    chk("payload_stable", capChanged, 0);
                    chk("err", err, e.err);
                end
            end else if (rst && err) begin
                checks++;
                failures++;
                $display("FAIL stray_err: got 1 expected 0");
            end
            prevInst = inst_rdata;
            prevData = data_rdata;
        end
    end

    task automatic waitOk(input bit isData, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(isData ? data_data_ok : inst_data_ok) && cyc < budget);
        if (!(isData ? data_data_ok : inst_data_ok)) begin
            checks++;
            failures++;
            $display("FAIL wait_data_ok: got no pulse within %0d cycles expected pulse", budget);
        end
    endtask

    task automatic runPair(input int budget);
        int n = 0;
        while ((inst_req || data_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (inst_data_ok) inst_req = 1'b0;
            if (data_data_ok) data_req = 1'b0;
        end
        if (inst_req || data_req) begin
            checks++;
            failures++;
            $display("FAIL pair_complete: got pending inst=%0b data=%0b expected none", inst_req, data_req);
            inst_req = 1'b0;
            data_req = 1'b0;
        end
    endtask

    function automatic exp_t mk(input bit isData, input logic [31:0] addr, input bit wr,
                                input logic [3:0] sel, input logic [31:0] wdata,
                                input logic [31:0] rdata, input bit e, input int rc);
        exp_t x;
        x.isData = isData; x.addr = addr; x.wr = wr; x.sel = sel;
        x.wdata = wdata; x.rdata = rdata; x.err = e; x.reqCycles = rc;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h12345678;
        data_req = 1'b1; data_wr = 1'b1; data_sel = 4'hF;
        data_addr = 32'h87654321; data_wdata = 32'hFFFFFFFF;

        // Reset state with requests asserted.
        @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_wr", bus_wr, 0);
        chk("rst_bus_sel", bus_sel, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_busy_err", {busy, err}, 0);
        inst_req = 1'b0; data_req = 1'b0;
        data_wr = 1'b0; data_wdata = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single inst read at minimum latency.
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        expQ.push_back(mk(0, 32'hBFC00000, 0, 4'hF, 32'd0, 32'h24080001, 0, 1));
        waitOk(0, 20, cyc);
        inst_req = 1'b0;
        chk("inst_latency", cyc, 3);
        @(negedge clk);

        // Data write with addr_ok delayed 3 cycles.
        addrDelay = 3;
        data_req = 1'b1; data_wr = 1'b1; data_sel = 4'b0011;
        data_addr = 32'h80000010; data_wdata = 32'h0000ABCD;
        expQ.push_back(mk(1, 32'h80000010, 1, 4'b0011, 32'h0000ABCD, 32'h7FFFFFEF, 0, 4));
        waitOk(1, 30, cyc);
        data_req = 1'b0; data_wr = 1'b0; data_sel = 4'hF; data_wdata = 32'd0;
        chk("write_latency", cyc, 6);
        @(negedge clk);
        chk("data_ok_single_pulse", data_data_ok, 0);
        addrDelay = 0;

        // req held through its data_ok cycle: regrant only in the following cycle.
        data_req = 1'b1; data_addr = 32'h80000020;
        expQ.push_back(mk(1, 32'h80000020, 0, 4'hF, 32'd0, 32'h7FFFFFDF, 0, 1));
        waitOk(1, 20, cyc);
        data_addr = 32'h80000040;
        expQ.push_back(mk(1, 32'h80000040, 0, 4'hF, 32'd0, 32'h7FFFFFBF, 0, 1));
        @(negedge clk);
        chk("no_regrant_in_ok_cycle", busy, 0);
        @(negedge clk);
        chk("regrant_next_cycle", busy, 1);
        waitOk(1, 20, cyc);
        data_req = 1'b0;
        @(negedge clk);

        // Both requests across reset release: data first, then alternating.
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_addr = 32'h80000020;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        expQ.push_back(mk(1, 32'h80000020, 0, 4'hF, 32'd0, 32'h7FFFFFDF, 0, 1));
        expQ.push_back(mk(0, 32'hBFC00004, 0, 4'hF, 32'd0, 32'h403FFFFB, 0, 1));
        runPair(40);
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1;
        expQ.push_back(mk(1, 32'h80000020, 0, 4'hF, 32'd0, 32'h7FFFFFDF, 0, 1));
        expQ.push_back(mk(0, 32'hBFC00004, 0, 4'hF, 32'd0, 32'h403FFFFB, 0, 1));
        runPair(40);
        @(negedge clk);

        // Asynchronous reset while in D_DATA abandons the transaction.
        holdData = 1'b1;
        data_req = 1'b1; data_addr = 32'h80000030;
        repeat (3) @(negedge clk);
        chk("busy_in_d_data", busy, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_bus_req", bus_req, 0);
        chk("async_rst_busy", busy, 0);
        data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        holdData = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_ok_after_abandon", data_data_ok, 0);
        end
        chk("rdata_after_abandon", data_rdata, 0);
        chk("idle_after_abandon", busy, 0);

        // Data phase that never completes.
        holdData = 1'b1;
        data_req = 1'b1; data_addr = 32'h80000050;
`ifdef ARB_TIMEOUT_EN
        expQ.push_back(mk(1, 32'h80000050, 0, 4'hF, 32'd0, 32'hDEADBEEF, 1, 1));
        waitOk(1, 400, cyc);
        data_req = 1'b0;
        chk("timeout_latency", cyc, 257);
        @(posedge clk);
        respPhase = 0;
        holdData  = 1'b0;
`else
        repeat (300) @(negedge clk);
        chk("busy_without_timeout", busy, 1);
        chk("err_without_timeout", err, 0);
        rst = 1'b0;
        data_req = 1'b0;
        @(posedge clk);
        respPhase = 0;
        reqCount  = 0;
        holdData  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have port clk input 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst input 1: asynchronous, active-low reset.
REQ-003 SHALL have inst-side ports: inst_req in 1, inst_addr in 32, inst_rdata out 32, inst_data_ok out 1.
REQ-004 SHALL have data-side ports: data_req in 1, data_wr in 1, data_sel in 4, data_addr in 32, data_wdata in 32, data_rdata out 32, data_data_ok out 1.
REQ-005 SHALL have bus-side ports: bus_req out 1, bus_wr out 1, bus_sel out 4, bus_addr out 32, bus_wdata out 32, bus_addr_ok in 1, bus_data_ok in 1, bus_rdata in 32.
REQ-006 SHALL have status ports: busy out 1 (state != IDLE), err out 1 (timeout pulse, see Configuration).

Function
REQ-007 SHALL implement FSM states IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
REQ-008 IDLE: sample requests; grant one, latch its addr/wr/sel/wdata into holding registers, go to I_ADDR or D_ADDR next cycle.
REQ-009 Conflict (both req in IDLE): grant side opposite to last_grant; single request always granted regardless of last_grant.
REQ-010 last_grant SHALL update only on grant.
REQ-011 *_ADDR: bus_req=1, bus_* driven from holding registers; stay until bus_addr_ok=1, then go to *_DATA.
REQ-012 *_DATA: bus_req=0; stay until bus_data_ok=1; then capture bus_rdata into granted side's rdata register, go to IDLE.
REQ-013 Granted side's *_data_ok SHALL pulse exactly one cycle, the cycle after bus_data_ok (first IDLE cycle); rdata holds until next completion for that side.
REQ-014 Inst grants SHALL drive bus_wr=0, bus_sel=4'b1111, bus_wdata=0.
REQ-015 In the cycle a side's *_data_ok is high, that side's req SHALL be ignored; the other side may be granted.
REQ-016 Requesters hold req and payload until data_ok; req dropped before grant is a withdrawal with no bus activity.
REQ-017 Minimum latency: req sampled cycle N, bus_req cycle N+1, addr_ok N+1, data_ok N+2, *_data_ok N+3.
REQ-018 bus_addr_ok outside *_ADDR and bus_data_ok outside *_DATA SHALL be ignored.
REQ-019 Non-granted side SHALL see no data_ok and no rdata change.

Reset
REQ-020 rst=0 SHALL immediately force state IDLE, last_grant=inst, bus_req=0, bus_wr=0, bus_sel=0, bus_addr=0, bus_wdata=0, inst_rdata=0, data_rdata=0, both data_ok=0, busy=0, err=0, timeout counter=0.
REQ-021 Reset mid-transaction SHALL abandon it with no data_ok pulse; first grant after release follows REQ-009 (conflict gives data).

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: 8-bit counter cleared on entering *_DATA, increments each *_DATA cycle; reaching 255 with no bus_data_ok forces IDLE, pulses granted *_data_ok and err one cycle, rdata=32'hDEADBEEF.
REQ-023 ARB_TIMEOUT_EN undefined: no counter, *_DATA waits indefinitely, err tied 0.

Verification
REQ-024 Single inst read addr 0xBFC00000, addr_ok immediate, bus_rdata 0x24080001 one cycle later -> inst_data_ok pulse at N+3, inst_rdata=0x24080001, bus_wr=0.
REQ-025 Both req at reset release -> data granted first (bus_addr=data_addr), then inst; a second simultaneous pair -> data again only after inst, alternating.
REQ-026 Data write addr 0x80000010, sel 4'b0011, wdata 0x0000ABCD, addr_ok delayed 3 cycles -> bus_req high 4 cycles with stable payload, bus_wr=1, data_data_ok pulse once.
REQ-027 Requester keeps req high during its data_ok cycle -> no regrant that cycle; regrant next cycle.
REQ-028 rst low during D_DATA -> bus_req/busy 0 at once, no data_data_ok, later bus_data_ok ignored.
REQ-029 With ARB_TIMEOUT_EN, bus_data_ok never asserted -> err and data_data_ok pulse 255 cycles after D_DATA entry, data_rdata=0xDEADBEEF; without macro, busy stays 1.
